render_sequencer: RTL

Parametrised frame-render scheduler for the game display path. It is the successor to the fixed tile/bomb/player/HP draw loop: it generalises to NUM_LAYERS sprite layers, each with a runtime item count. Each frame it walks every non-empty layer, issuing one draw job per item through a req/done handshake, then requests a screen present. It then idles until an internal divider produces the next frame tick. The block sits between the game controller (start/stop, per-layer counts) and the datapath copy/print engines.

---
 rtl/render_sequencer_pkg.sv | 33 +++
 rtl/render_sequencer_if.sv | 38 +++
 rtl/render_sequencer_tick_divider.sv | 40 ++++
 rtl/render_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/render_sequencer_pkg.sv
// Shared definitions for the render sequencer: FSM state encoding, derived-width
// helpers and the slice macro that extracts one layer's count from the packed bus.
`define RS_LAYER_SLICE(vec, idx, cw) vec[(idx)*(cw) +: (cw)]

package render_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SCAN,
      ST_DRAW,
      ST_PRESENT,
      ST_WAIT
   } state_e;

   function automatic int lw_f(input int num_layers);
      return (num_layers > 1) ? $clog2(num_layers) : 1;
   endfunction

   function automatic int iw_f(input int max_items);
      return (max_items > 1) ? $clog2(max_items) : 1;
   endfunction

   function automatic int cw_f(input int max_items);
      return $clog2(max_items + 1);
   endfunction

   // The internal layer counter must be able to hold NUM_LAYERS to mark end-of-scan.
   function automatic int lqw_f(input int num_layers);
      return (num_layers > 1) ? $clog2(num_layers + 1) : 1;
   endfunction

endpackage

// File: rtl/render_sequencer_if.sv
// Controller/datapath-facing signal bundle of the render sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface render_sequencer_if
   import render_sequencer_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int MAX_ITEMS  = 8
);

   localparam int LW = lw_f(NUM_LAYERS);
   localparam int IW = iw_f(MAX_ITEMS);
   localparam int CW = cw_f(MAX_ITEMS);

   logic                     start;
   logic                     stop;
   logic [NUM_LAYERS*CW-1:0] layer_count;
   logic                     draw_req;
   logic [LW-1:0]            layer_id;
   logic [IW-1:0]            item_id;
   logic                     draw_done;
   logic                     present_req;
   logic                     present_done;
   logic                     frame_tick;
   logic                     anim_tick;
   logic                     busy;
   logic                     overrun;

   modport master (
      output start, stop, layer_count, draw_done, present_done,
      input  draw_req, layer_id, item_id, present_req, frame_tick, anim_tick, busy, overrun
   );

   modport slave (
      input  start, stop, layer_count, draw_done, present_done,
      output draw_req, layer_id, item_id, present_req, frame_tick, anim_tick, busy, overrun
   );

endinterface

// File: rtl/render_sequencer_tick_divider.sv
// Modulo-DIV event counter: tick is high on the enabled cycle that completes a
// full DIV count; clear holds the count at zero.
module tick_divider #(
   parameter int DIV = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      // NOTE: cnt_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: registers are written with <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/render_sequencer.sv
// Frame-render scheduler: snapshots per-layer item counts, issues one draw job per
// item over a req/done handshake, requests a present, then waits for the frame tick.
module render_sequencer
   import render_sequencer_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int MAX_ITEMS  = 8,
   parameter int CLK_DIV    = 833333,
   parameter int FRAME_DIV  = 15
) (
   input logic               clock,
   input logic               reset,
   render_sequencer_if.slave bus
);

   localparam int             LW         = lw_f(NUM_LAYERS);
   localparam int             IW         = iw_f(MAX_ITEMS);
   localparam int             CW         = cw_f(MAX_ITEMS);
   localparam int             LQW        = lqw_f(NUM_LAYERS);
   localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_ITEMS);
   localparam logic [LQW-1:0] LAST_LAYER = LQW'(NUM_LAYERS - 1);
   localparam logic [LQW-1:0] END_LAYER  = LQW'(NUM_LAYERS);

   state_e         state_q;
   logic [CW-1:0]  snap_q [NUM_LAYERS];
   logic [CW-1:0]  snap_d [NUM_LAYERS];
   logic [LQW-1:0] layer_q;
   logic [IW-1:0]  item_q;
   logic           draw_req_q;
   logic           present_req_q;
   logic           busy_q;
   logic           overrun_q;

   logic [CW-1:0]  cur_cnt;
   logic           last_item;
   logic           div_clear;
   logic           frame_tick;
   logic           anim_tick;

   // Clamp each incoming count so a bad controller value can never overrun item_id.
   always_comb begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
         snap_d[i] = (`RS_LAYER_SLICE(bus.layer_count, i, CW) > MAX_CNT)
                   ? MAX_CNT : `RS_LAYER_SLICE(bus.layer_count, i, CW);
      end
   end

   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (layer_q == LQW'(i)) begin
            cur_cnt = snap_q[i];
         end
      end
   end

   assign last_item = (CW'(item_q) == cur_cnt - 1'b1);

   assign div_clear = (state_q == ST_IDLE) || bus.stop;

   tick_divider #(.DIV(CLK_DIV)) u_frame_div (
      .clock  (clock),
      .reset  (reset),
      .clear  (div_clear),
      .enable (1'b1),
      .tick   (frame_tick)
   );

   tick_divider #(.DIV(FRAME_DIV)) u_anim_div (
      .clock  (clock),
      .reset  (reset),
      .clear  (div_clear),
      .enable (frame_tick),
      .tick   (anim_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         layer_q       <= '0;
         item_q        <= '0;
         draw_req_q    <= 1'b0;
         present_req_q <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         // NOTE: the snapshot is a handful of flops and is reset explicitly; no stale count survives reset.
         for (int i = 0; i < NUM_LAYERS; i++) begin
            snap_q[i] <= '0;
         end
      end else if (bus.stop) begin
         state_q       <= ST_IDLE;
         layer_q       <= '0;
         item_q        <= '0;
         draw_req_q    <= 1'b0;
         present_req_q <= 1'b0;
         busy_q        <= 1'b0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         // A tick seen anywhere but WAIT is lost; the frame still runs to completion.
         if (frame_tick && (state_q != ST_IDLE) && (state_q != ST_WAIT)) begin
            overrun_q <= 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q   <= ST_LATCH;
                  busy_q    <= 1'b1;
                  overrun_q <= 1'b0;
               end
            end

            ST_LATCH: begin
               snap_q  <= snap_d;
               layer_q <= '0;
               item_q  <= '0;
               state_q <= ST_SCAN;
            end

            ST_SCAN: begin
               if (layer_q == END_LAYER) begin
                  state_q       <= ST_PRESENT;
                  present_req_q <= 1'b1;
               end else if (cur_cnt == '0) begin
                  layer_q <= layer_q + 1'b1;
                  // Skipping the final empty layer goes straight to PRESENT.
                  if (layer_q == LAST_LAYER) begin
                     state_q       <= ST_PRESENT;
                     present_req_q <= 1'b1;
                  end
               end else begin
                  state_q    <= ST_DRAW;
                  draw_req_q <= 1'b1;
               end
            end

            ST_DRAW: begin
               if (bus.draw_done) begin
                  if (last_item) begin
                     item_q     <= '0;
                     layer_q    <= layer_q + 1'b1;
                     state_q    <= ST_SCAN;
                     draw_req_q <= 1'b0;
                  end else begin
                     item_q <= item_q + 1'b1;
                  end
               end
            end

            ST_PRESENT: begin
               if (bus.present_done) begin
                  state_q       <= ST_WAIT;
                  present_req_q <= 1'b0;
               end
            end

            ST_WAIT: begin
               if (frame_tick) begin
                  state_q <= ST_LATCH;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.draw_req    = draw_req_q;
   assign bus.layer_id    = layer_q[LW-1:0];
   assign bus.item_id     = item_q;
   assign bus.present_req = present_req_q;
   assign bus.busy        = busy_q;
   assign bus.overrun     = overrun_q;
   assign bus.frame_tick  = frame_tick;
   assign bus.anim_tick   = anim_tick;

endmodule
